// File: rtl/id_branch_resolver.sv
// ID-stage branch resolver: detects load/ALU hazards on branch sources, stalls
// until operands are forwardable, then resolves the branch and redirects fetch.
module id_branch_resolver #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
)(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_kill,
  input  logic [2:0]        i_branch_op,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic [PC_W-1:0]   i_pc_plus_4,
  input  logic [15:0]       i_offset,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_reg_write,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_reg_write,
  input  logic              i_mem_mem_read,
  input  logic [DATA_W-1:0] i_mem_alu_result,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_reg_write,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_stall,
  output logic              o_flush_idex,
  output logic              o_pc_src,
  output logic              o_flush_ifid,
  output logic [PC_W-1:0]   o_target,
  output logic [CNT_W-1:0]  o_branch_count,
  output logic [CNT_W-1:0]  o_taken_count
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_BLEZ = 3'b011;
  localparam logic [2:0] OP_BGTZ = 3'b100;
  localparam logic [2:0] OP_BLTZ = 3'b101;
  localparam logic [2:0] OP_BGEZ = 3'b110;

  logic [0:0]       r_state, w_next_state;
  logic [1:0]       r_cnt, w_next_cnt;
  logic [CNT_W-1:0] r_bcnt, r_tcnt;

  logic              w_active, w_uses_rt, w_stall, w_resolve, w_taken;
  logic [1:0]        w_need_rs, w_need_rt, w_need;
  logic [DATA_W-1:0] w_a, w_b;
  logic              w_neg, w_zero;
  logic [PC_W+17:0]  w_off_wide;
  logic [PC_W-1:0]   w_br_tgt, w_jr_tgt;

  // Cycles a source must wait before its producer can be forwarded into ID.
  function automatic logic [1:0] src_stall(input logic [REG_AW-1:0] r);
    if (r == '0)                                  return 2'd0;
    else if (i_ex_rd == r && i_ex_mem_read)       return 2'd2;
    else if (i_ex_rd == r && i_ex_reg_write)      return 2'd1;
    else if (i_mem_rd == r && i_mem_mem_read)     return 2'd1;
    else                                          return 2'd0;
  endfunction

  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] r,
                                            input logic [DATA_W-1:0] rf);
    if (r == '0)                                              return '0;
    else if (i_mem_reg_write && !i_mem_mem_read && i_mem_rd == r) return i_mem_alu_result;
    else if (i_wb_reg_write && i_wb_rd == r)                  return i_wb_data;
    else                                                      return rf;
  endfunction

  assign w_active  = i_valid & ~i_kill & (i_branch_op != OP_NONE);
  assign w_uses_rt = (i_branch_op == OP_BEQ) | (i_branch_op == OP_BNE);
  assign w_need_rs = src_stall(i_rs);
  assign w_need_rt = w_uses_rt ? src_stall(i_rt) : 2'd0;
  assign w_need    = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;

  assign w_a    = fwd(i_rs, i_rs_data);
  assign w_b    = fwd(i_rt, i_rt_data);
  assign w_neg  = w_a[DATA_W-1];
  assign w_zero = (w_a == '0);

  always_comb begin
    w_taken = 1'b0;
    case (i_branch_op)
      OP_BEQ:  w_taken = (w_a == w_b);
      OP_BNE:  w_taken = (w_a != w_b);
      OP_BLEZ: w_taken = w_neg | w_zero;
      OP_BGTZ: w_taken = ~w_neg & ~w_zero;
      OP_BLTZ: w_taken = w_neg;
      OP_BGEZ: w_taken = ~w_neg;
      OP_NONE: w_taken = 1'b0;
      default: w_taken = 1'b1;
    endcase
  end

  assign w_off_wide = {{PC_W{i_offset[15]}}, i_offset, 2'b00};
  assign w_br_tgt   = i_pc_plus_4 + w_off_wide[PC_W-1:0];

  generate
    if (DATA_W >= PC_W) begin : g_jr_trunc
      assign w_jr_tgt = w_a[PC_W-1:0];
    end else begin : g_jr_zext
      assign w_jr_tgt = {{(PC_W-DATA_W){1'b0}}, w_a};
    end
  endgenerate

  always_comb begin
    w_stall      = 1'b0;
    w_resolve    = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_active) begin
          if (w_need != 2'd0) begin
            w_stall      = 1'b1;
            w_next_cnt   = w_need - 2'd1;
            w_next_state = (w_need > 2'd1) ? S_STALL : S_IDLE;
          end else begin
            w_resolve = 1'b1;
          end
        end
      end
      default: begin
        // A squashed or vanished instruction releases the stall immediately.
        if (i_kill || !i_valid) begin
          w_next_state = S_IDLE;
          w_next_cnt   = 2'd0;
        end else begin
          w_stall      = 1'b1;
          w_next_cnt   = r_cnt - 2'd1;
          w_next_state = (r_cnt == 2'd1) ? S_IDLE : S_STALL;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_bcnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_resolve && !(&r_bcnt))           r_bcnt <= r_bcnt + CNT_W'(1);
      if (w_resolve && w_taken && !(&r_tcnt)) r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

  assign o_stall        = i_reset & w_stall;
  assign o_flush_idex   = o_stall;
  assign o_pc_src       = i_reset & w_resolve & w_taken;
  assign o_flush_ifid   = o_pc_src;
  assign o_target       = !i_reset ? '0 : ((i_branch_op == 3'b111) ? w_jr_tgt : w_br_tgt);
  assign o_branch_count = r_bcnt;
  assign o_taken_count  = r_tcnt;
endmodule

// File: tb/tb_id_branch_resolver.sv
// Bench for id_branch_resolver: directed scenarios plus random traffic checked
// against a remaining-stall-cycles reference model.
module tb_id_branch_resolver;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, kill;
  logic [2:0]  op;
  logic [4:0]  rs, rt, ex_rd, mem_rd, wb_rd;
  logic [31:0] rs_d, rt_d, pc4, mem_res, wb_d;
  logic [15:0] off;
  logic        ex_rw, ex_mr, mem_rw, mem_mr, wb_rw;
  logic        stall, fl_idex, pc_src, fl_ifid;
  logic [31:0] tgt;
  logic [15:0] bcnt, tcnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_left = 0;
  int m_bcnt = 0;
  int m_tcnt = 0;

  always #5 clk = ~clk;

  id_branch_resolver dut (
    .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_kill(kill),
    .i_branch_op(op), .i_rs(rs), .i_rt(rt), .i_rs_data(rs_d), .i_rt_data(rt_d),
    .i_pc_plus_4(pc4), .i_offset(off),
    .i_ex_rd(ex_rd), .i_ex_reg_write(ex_rw), .i_ex_mem_read(ex_mr),
    .i_mem_rd(mem_rd), .i_mem_reg_write(mem_rw), .i_mem_mem_read(mem_mr),
    .i_mem_alu_result(mem_res),
    .i_wb_rd(wb_rd), .i_wb_reg_write(wb_rw), .i_wb_data(wb_d),
    .o_stall(stall), .o_flush_idex(fl_idex), .o_pc_src(pc_src), .o_flush_ifid(fl_ifid),
    .o_target(tgt), .o_branch_count(bcnt), .o_taken_count(tcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    valid = 0; kill = 0; op = 0; rs = 0; rt = 0; rs_d = 0; rt_d = 0;
    pc4 = 0; off = 0; ex_rd = 0; ex_rw = 0; ex_mr = 0;
    mem_rd = 0; mem_rw = 0; mem_mr = 0; mem_res = 0;
    wb_rd = 0; wb_rw = 0; wb_d = 0;
  endtask

  // Wait the producer of register r imposes on a branch reading it in ID.
  function automatic int hz(input logic [4:0] r);
    if (r == 0) return 0;
    if (r == ex_rd && ex_mr) return 2;
    if (r == ex_rd && ex_rw) return 1;
    if (r == mem_rd && mem_mr) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 0;
    if (mem_rw && !mem_mr && mem_rd == r) return mem_res;
    if (wb_rw && wb_rd == r) return wb_d;
    return rf;
  endfunction

  // Called just after a falling edge with inputs applied; checks this cycle,
  // advances the model across the next rising edge, returns at the next falling edge.
  task automatic cyc();
    int n, sa, sb, so;
    bit e_stall, e_res, e_tk;
    logic [31:0] e_tgt;
    #1;
    e_stall = 0; e_res = 0; e_tk = 0;
    sa = opnd(rs, rs_d);
    sb = opnd(rt, rt_d);
    so = $signed(off);
    case (op)
      3'd1: e_tk = (sa == sb);
      3'd2: e_tk = (sa != sb);
      3'd3: e_tk = (sa <= 0);
      3'd4: e_tk = (sa > 0);
      3'd5: e_tk = (sa < 0);
      3'd6: e_tk = (sa >= 0);
      3'd7: e_tk = 1;
      default: e_tk = 0;
    endcase
    e_tgt = (op == 3'd7) ? sa : pc4 + so * 4;
    if (m_left > 0) begin
      if (kill || !valid) m_left = 0;
      else begin e_stall = 1; m_left--; end
    end else if (valid && !kill && op != 0) begin
      n = hz(rs);
      if ((op == 3'd1 || op == 3'd2) && hz(rt) > n) n = hz(rt);
      if (n > 0) begin e_stall = 1; m_left = n - 1; end
      else e_res = 1;
    end
    chk("stall", stall, e_stall);
    chk("flush_idex", fl_idex, e_stall);
    chk("pc_src", pc_src, e_res & e_tk);
    chk("flush_ifid", fl_ifid, e_res & e_tk);
    if (e_res && e_tk) chk("target", tgt, e_tgt);
    chk("branch_count", bcnt, m_bcnt);
    chk("taken_count", tcnt, m_tcnt);
    if (e_res && m_bcnt < 16'hFFFF) m_bcnt++;
    if (e_res && e_tk && m_tcnt < 16'hFFFF) m_tcnt++;
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    rst_n = 0;
    valid = 1; op = 3'd7;  // active JR under reset must still be silenced
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_pc_src", pc_src, 0);
    chk("rst_flush_ifid", fl_ifid, 0);
    chk("rst_target", tgt, 0);
    chk("rst_bcnt", bcnt, 0);
    @(negedge clk);
    rst_n = 1;
    clr_in();

    // BEQ taken, backward offset
    valid = 1; op = 3'd1; rs = 3; rt = 4; rs_d = 7; rt_d = 7; pc4 = 32'h100; off = 16'hFFFF;
    #1;
    chk("beq_pc_src", pc_src, 1);
    chk("beq_target", tgt, 32'hFC);
    cyc();
    clr_in(); cyc();
    chk("beq_counts", {bcnt, tcnt}, {16'd1, 16'd1});

    // BNE behind a load: two stall cycles, then WB forward
    clr_in(); valid = 1; op = 3'd2; rs = 5; rt = 6; rs_d = 9; rt_d = 9; pc4 = 32'h200; off = 16'h0010;
    ex_rd = 5; ex_rw = 1; ex_mr = 1;
    #1 chk("bne_stall1", stall, 1); cyc();
    ex_rd = 0; ex_rw = 0; ex_mr = 0; mem_rd = 5; mem_rw = 1; mem_mr = 1;
    #1 chk("bne_stall2", stall, 1); cyc();
    mem_rd = 0; mem_rw = 0; mem_mr = 0; wb_rd = 5; wb_rw = 1; wb_d = 32'h1234;
    #1 chk("bne_wb_taken", pc_src, 1); cyc();

    // BGTZ behind ALU write: one stall, then MEM forward of a negative value
    clr_in(); valid = 1; op = 3'd4; rs = 2; rs_d = 5; ex_rd = 2; ex_rw = 1;
    cyc();
    ex_rd = 0; ex_rw = 0; mem_rd = 2; mem_rw = 1; mem_res = 32'h8000_0000;
    #1 chk("bgtz_not_taken", pc_src, 0); cyc();

    // JR via r0 never stalls
    clr_in(); valid = 1; op = 3'd7; rs = 0; rs_d = 32'hDEAD; ex_rd = 0; ex_rw = 1;
    #1 chk("jr_r0_target", tgt, 0); cyc();

    // Kill in the first cycle of a load stall
    clr_in(); valid = 1; kill = 1; op = 3'd3; rs = 7; ex_rd = 7; ex_rw = 1; ex_mr = 1;
    cyc();
    valid = 1; kill = 0; cyc();
    kill = 1; cyc();
    clr_in(); cyc();

    // Random traffic over a small register window so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(7) != 0); kill = ($urandom_range(7) == 0);
      op = $urandom_range(7); rs = $urandom_range(3); rt = $urandom_range(3);
      rs_d = $urandom; rt_d = ($urandom_range(3) == 0) ? rs_d : $urandom;
      pc4 = $urandom; off = $urandom;
      ex_rd = $urandom_range(3); ex_rw = $urandom; ex_mr = $urandom;
      mem_rd = $urandom_range(3); mem_rw = $urandom; mem_mr = $urandom; mem_res = $urandom;
      wb_rd = $urandom_range(3); wb_rw = $urandom; wb_d = $urandom;
      if ($urandom_range(3) == 0) begin rs_d = 0; mem_res = 0; wb_d = 0; end
      cyc();
    end

    // Drive counters into saturation with back-to-back taken JRs
    clr_in(); valid = 1; op = 3'd7;
    for (int i = 0; i < 65540; i++) cyc();
    chk("sat_bcnt", bcnt, 16'hFFFF);
    chk("sat_tcnt", tcnt, 16'hFFFF);

    // Asynchronous reset in the middle of a load stall
    clr_in(); valid = 1; op = 3'd1; rs = 4; rt = 4; ex_rd = 4; ex_rw = 1; ex_mr = 1;
    cyc();
    #2 rst_n = 0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_flush_idex", fl_idex, 0);
    chk("mid_rst_pc_src", pc_src, 0);
    chk("mid_rst_target", tgt, 0);
    chk("mid_rst_bcnt", bcnt, 0);
    chk("mid_rst_tcnt", tcnt, 0);
    m_left = 0; m_bcnt = 0; m_tcnt = 0;
    @(negedge clk);
    rst_n = 1;
    clr_in(); valid = 1; op = 3'd6; rs = 1; rs_d = 32'h5; pc4 = 32'h40; off = 16'h0002;
    #1 chk("post_rst_resolve", pc_src, 1);
    cyc();
    clr_in(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
